reduce_stream_arbiter: RTL and testbench

//  Shares one reduce/accumulate unit among NUM_REQ sparse 17-bit token streams (bit16 = eos).

---
 rtl/reduce_stream_arbiter_pkg.sv | 41 ++++
 rtl/reduce_stream_arbiter_id_fifo.sv | 60 ++++++
 rtl/reduce_stream_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_reduce_stream_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_stream_arbiter_pkg.sv
// Shared types and constants for the reduce stream arbiter: FSM encoding,
// token field positions and the ID FIFO entry layout.
package reduce_arb_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_FWD  = 1'b1;

   typedef enum logic [0:0] {
      IDLE = ST_IDLE,
      FWD  = ST_FWD
   } arb_state_t;

   localparam int EOS_BIT = 16;
   localparam int LVL_HI  = 9;
   localparam int LVL_LO  = 8;

   localparam logic [1:0] LVL_STOP = 2'h0;
   localparam logic [1:0] LVL_DONE = 2'h1;

   // Requester index field; wide enough for up to 16 requesters.
   localparam int ID_W = 4;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [1:0]      cnt;
   } id_entry_t;

   localparam int ENTRY_W = $bits(id_entry_t);

   // Number of results the reduce unit returns for an eos token; 0 marks an illegal level.
   function automatic logic [1:0] eos_result_cnt(input logic [1:0] lvl, input logic [7:0] stop);
      logic [1:0] cnt;
      case (lvl)
         LVL_STOP: cnt = (stop != 8'h00) ? 2'd2 : 2'd1;
         LVL_DONE: cnt = 2'd1;
         default:  cnt = 2'd0;
      endcase
      return cnt;
   endfunction

endpackage

// File: rtl/reduce_stream_arbiter_id_fifo.sv
// Register-based FIFO holding {requester id, expected result count} for every
// segment forwarded to the reduce unit. Same-cycle push and pop are supported.
module reduce_arb_id_fifo
   import reduce_arb_pkg::*;
#(
   parameter int WIDTH = ENTRY_W,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign empty_o    = (count_q == (AW+1)'(0));
   assign pop_data_o = mem_q[rd_ptr_q];
   assign do_push_s  = clk_en_i & push_i & ~full_o;
   assign do_pop_s   = clk_en_i & pop_i & ~empty_o;

   // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/reduce_stream_arbiter.sv
// Round-robin arbiter sharing one reduce unit among NUM_REQ token streams, with
// result routing through an ID FIFO. Define REDUCE_ARB_PERF_EN for per-requester counters.
module reduce_stream_arbiter
   import reduce_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 17,
   parameter int ID_DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clk_en,
   input  logic [NUM_REQ-1:0]        cfg_req_mask,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         red_in_data,
   output logic                      red_in_valid,
   input  logic                      red_in_ready,
   input  logic [DATA_W-1:0]         red_out_data,
   input  logic                      red_out_valid,
   output logic                      red_out_ready,
   output logic [NUM_REQ*DATA_W-1:0] rsp_data,
   output logic [NUM_REQ-1:0]        rsp_valid,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic                      err_bad_token
`ifdef REDUCE_ARB_PERF_EN
   ,
   output logic [15:0]               perf_seg_cnt   [NUM_REQ],
   output logic [15:0]               perf_stall_cnt [NUM_REQ]
`endif
);

   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   rr_q, rr_d;
   logic              err_q, err_d;
   logic [1:0]        ret_cnt_q, ret_cnt_d;

   logic [DATA_W-1:0] cur_data_s;
   logic              cur_valid_s;
   logic              cur_eos_s;
   logic [1:0]        cur_lvl_s;
   logic [7:0]        cur_stop_s;
   logic [1:0]        push_cnt_s;
   logic              fwd_s;
   logic              eos_ok_s;
   logic              in_hs_s;
   logic              push_s;
   logic              bad_s;
   logic              pop_s;
   logic              out_hs_s;
   logic              id_full_s;
   logic              id_empty_s;
   id_entry_t         push_entry_s;
   id_entry_t         head_s;
   logic [ENTRY_W-1:0] head_bits_s;
   logic [NUM_REQ-1:0] elig_s;
   logic [ID_W-1:0]   cand_s;
   logic              hit_s;
   logic              found_s;
   logic [ID_W-1:0]   sel_s;

   // Granted requester's packet, selected by one-hot masking so it stays purely combinational.
   always_comb begin
      cur_data_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cur_data_s = cur_data_s | ({DATA_W{grant_q == ID_W'(i)}} & req_data[i*DATA_W +: DATA_W]);
      end
   end

   assign cur_valid_s = |(req_valid & (NUM_REQ'(1) << grant_q));
   assign cur_eos_s   = cur_data_s[DATA_W-1];
   assign cur_lvl_s   = cur_data_s[LVL_HI:LVL_LO];
   assign cur_stop_s  = cur_data_s[7:0];
   assign push_cnt_s  = eos_result_cnt(cur_lvl_s, cur_stop_s);

   // Handshakes are suppressed while clk_en is low so no transfer happens in a held cycle.
   assign fwd_s        = clk_en & (state_q == FWD);
   assign eos_ok_s     = ~cur_eos_s | ~id_full_s;
   assign red_in_data  = cur_data_s;
   assign red_in_valid = fwd_s & cur_valid_s & eos_ok_s;
   assign req_ready    = (fwd_s & red_in_ready & eos_ok_s) ? (NUM_REQ'(1) << grant_q) : '0;
   assign in_hs_s      = red_in_valid & red_in_ready;
   assign push_s       = in_hs_s & cur_eos_s & (push_cnt_s != 2'd0);
   assign bad_s        = in_hs_s & cur_eos_s & (push_cnt_s == 2'd0);

   assign push_entry_s.id  = grant_q;
   assign push_entry_s.cnt = push_cnt_s;

   assign head_s        = id_entry_t'(head_bits_s);
   assign rsp_data      = {NUM_REQ{red_out_data}};
   assign rsp_valid     = (clk_en & red_out_valid & ~id_empty_s) ? (NUM_REQ'(1) << head_s.id) : '0;
   assign red_out_ready = clk_en & ~id_empty_s & (|(rsp_ready & (NUM_REQ'(1) << head_s.id)));
   assign out_hs_s      = red_out_valid & red_out_ready;
   assign pop_s         = out_hs_s & ((ret_cnt_q + 2'd1) == head_s.cnt);
   assign err_bad_token = err_q;

   // Round-robin search from rr_q: first eligible requester wins.
   always_comb begin
      elig_s  = req_valid & cfg_req_mask;
      found_s = 1'b0;
      sel_s   = '0;
      cand_s  = '0;
      hit_s   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_s  = ((int'(rr_q) + k) >= NUM_REQ) ? ID_W'(int'(rr_q) + k - NUM_REQ)
                                                 : ID_W'(int'(rr_q) + k);
         hit_s   = |(elig_s & (NUM_REQ'(1) << cand_s));
         sel_s   = (~found_s & hit_s) ? cand_s : sel_s;
         found_s = found_s | hit_s;
      end
   end

   // Segment FSM, sticky error and per-head result counter next-state.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      err_d     = err_q | bad_s;
      ret_cnt_d = out_hs_s ? (pop_s ? 2'd0 : ret_cnt_q + 2'd1) : ret_cnt_q;
      case (state_q)
         IDLE: begin
            if (found_s) begin
               grant_d = sel_s;
               rr_d    = (int'(sel_s) == NUM_REQ - 1) ? '0 : sel_s + ID_W'(1);
               state_d = FWD;
            end else begin
               state_d = IDLE;
            end
         end
         FWD: begin
            if (in_hs_s & cur_eos_s) begin
               state_d = IDLE;
            end else begin
               state_d = FWD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Arbiter state registers; everything holds while clk_en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         rr_q      <= '0;
         err_q     <= 1'b0;
         ret_cnt_q <= 2'd0;
      end else if (clk_en) begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         err_q     <= err_d;
         ret_cnt_q <= ret_cnt_d;
      end else begin
         state_q   <= state_q;
      end
   end

   reduce_arb_id_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (ID_DEPTH)
   ) u_id_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .clk_en_i    (clk_en),
      .push_i      (push_s),
      .push_data_i (push_entry_s),
      .pop_i       (pop_s),
      .pop_data_o  (head_bits_s),
      .full_o      (id_full_s),
      .empty_o     (id_empty_s)
   );

`ifdef REDUCE_ARB_PERF_EN
   logic [15:0] seg_cnt_q   [NUM_REQ];
   logic [15:0] stall_cnt_q [NUM_REQ];

   // Saturating per-requester segment and stall counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            seg_cnt_q[i]   <= 16'h0000;
            stall_cnt_q[i] <= 16'h0000;
         end
      end else if (clk_en) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (in_hs_s && cur_eos_s && (grant_q == ID_W'(i)) && (seg_cnt_q[i] != 16'hFFFF)) begin
               seg_cnt_q[i] <= seg_cnt_q[i] + 16'h0001;
            end
            if (fwd_s && (grant_q == ID_W'(i)) && req_valid[i] && !req_ready[i] &&
                (stall_cnt_q[i] != 16'hFFFF)) begin
               stall_cnt_q[i] <= stall_cnt_q[i] + 16'h0001;
            end
         end
      end else begin
         seg_cnt_q <= seg_cnt_q;
      end
   end

   assign perf_seg_cnt   = seg_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_reduce_stream_arbiter.sv
// Scoreboard bench for reduce_stream_arbiter: per-lane token queues drive the
// requesters, a small reduce-unit model answers, per-lane expected queues check routing.
module tb_reduce_stream_arbiter;

   localparam int NR    = 4;
   localparam int DW    = 17;
   localparam int DEPTH = 8;

   typedef logic [DW-1:0] tok_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clk_en;
   logic [NR-1:0]    cfg_req_mask;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [DW-1:0]    red_in_data;
   logic             red_in_valid;
   logic             red_in_ready;
   logic [DW-1:0]    red_out_data;
   logic             red_out_valid;
   logic             red_out_ready;
   logic [NR*DW-1:0] rsp_data;
   logic [NR-1:0]    rsp_valid;
   logic [NR-1:0]    rsp_ready;
   logic             err_bad_token;
`ifdef REDUCE_ARB_PERF_EN
   logic [15:0]      perf_seg_cnt   [NR];
   logic [15:0]      perf_stall_cnt [NR];
`endif

   tok_t          tokq [NR][$];
   tok_t          exp_q [NR][$];
   tok_t          res_q [$];
   int            eos_lane_q [$];
   int            eos_cyc_q [$];
   int            rsp_cnt [NR];
   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   logic [15:0]   model_sum;
   logic [NR-1:0] rsp_ready_cfg;

   reduce_stream_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ID_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clk_en        (clk_en),
      .cfg_req_mask  (cfg_req_mask),
      .req_data      (req_data),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .red_in_data   (red_in_data),
      .red_in_valid  (red_in_valid),
      .red_in_ready  (red_in_ready),
      .red_out_data  (red_out_data),
      .red_out_valid (red_out_valid),
      .red_out_ready (red_out_ready),
      .rsp_data      (rsp_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .err_bad_token (err_bad_token)
`ifdef REDUCE_ARB_PERF_EN
      ,
      .perf_seg_cnt   (perf_seg_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic tok_t mk_eos(input logic [1:0] lvl, input logic [7:0] stop);
      return {1'b1, 6'b000000, lvl, stop};
   endfunction

   // Queue one segment on a lane and record the results the reduce unit should send back.
   task automatic send_seg(input int lane, input int n, input int base,
                           input logic [1:0] lvl, input logic [7:0] stop);
      logic [15:0] sum = 16'h0000;
      for (int j = 0; j < n; j++) begin
         tokq[lane].push_back(tok_t'(base + j));
         sum = sum + 16'(base + j);
      end
      tokq[lane].push_back(mk_eos(lvl, stop));
      case (lvl)
         2'd0: begin
            exp_q[lane].push_back({1'b0, sum});
            if (stop != 8'd0) exp_q[lane].push_back(mk_eos(2'd0, stop - 8'd1));
         end
         2'd1:    exp_q[lane].push_back(mk_eos(2'd1, stop));
         default: ;
      endcase
   endtask

   task automatic model_accept(input tok_t d);
      if (!d[DW-1]) begin
         model_sum = model_sum + d[15:0];
      end else begin
         case (d[9:8])
            2'd0: begin
               res_q.push_back({1'b0, model_sum});
               if (d[7:0] != 8'd0) res_q.push_back(mk_eos(2'd0, d[7:0] - 8'd1));
            end
            2'd1:    res_q.push_back(d);
            default: ;
         endcase
         model_sum = 16'h0000;
      end
   endtask

   // One clock: drive at negedge, evaluate handshakes just after, before the next posedge.
   task automatic cycle();
      tok_t t;
      int   rsp_seen = 0;
      int   req_hs = 0;
      logic out_hs;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
         req_valid[i] = (tokq[i].size() != 0);
         req_data[i*DW +: DW] = req_valid[i] ? tokq[i][0] : '0;
      end
      red_out_valid = (res_q.size() != 0);
      red_out_data  = red_out_valid ? res_q[0] : '0;
      rsp_ready     = rsp_ready_cfg;
      #1;
      out_hs = red_out_valid && red_out_ready;
      for (int i = 0; i < NR; i++) begin
         if (rsp_valid[i] && rsp_ready[i]) begin
            rsp_seen++;
            rsp_cnt[i]++;
            if (exp_q[i].size() == 0) check_val("rsp_unexpected_lane", i, 32'hFFFF_FFFF);
            else check_val("rsp_data", rsp_data[i*DW +: DW], exp_q[i].pop_front());
         end
      end
      if (rsp_seen != 0 || out_hs) check_val("rsp_vs_out_hs", rsp_seen, out_hs ? 1 : 0);
      if (out_hs) void'(res_q.pop_front());
      for (int i = 0; i < NR; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            req_hs++;
            t = tokq[i].pop_front();
            check_val("fwd_data", red_in_data, t);
            if (t[DW-1]) begin
               eos_lane_q.push_back(i);
               eos_cyc_q.push_back(cyc);
            end
         end
      end
      if (req_hs != 0 || (red_in_valid && red_in_ready))
         check_val("req_vs_red_in_hs", req_hs, (red_in_valid && red_in_ready) ? 1 : 0);
      if (red_in_valid && red_in_ready) model_accept(red_in_data);
      cyc++;
   endtask

   function automatic bit all_idle();
      bit idle = (res_q.size() == 0);
      for (int i = 0; i < NR; i++) begin
         if (tokq[i].size() != 0 || exp_q[i].size() != 0) idle = 1'b0;
      end
      return idle;
   endfunction

   task automatic drain(input string tag, input int budget);
      int k = 0;
      while (!all_idle() && k < budget) begin
         cycle();
         k++;
      end
      check_val(tag, all_idle(), 1);
      cycle();
      cycle();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic clear_all();
      for (int i = 0; i < NR; i++) begin
         tokq[i].delete();
         exp_q[i].delete();
         rsp_cnt[i] = 0;
      end
      res_q.delete();
      eos_lane_q.delete();
      eos_cyc_q.delete();
      model_sum = 16'h0000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      rst_n = 1'b0; clk_en = 1'b1; cfg_req_mask = 4'hF;
      req_data = '0; req_valid = 4'h0; red_in_ready = 1'b1;
      red_out_data = '0; red_out_valid = 1'b0; rsp_ready = 4'h0; rsp_ready_cfg = 4'hF;
      clear_all();
      #1;
      check_val("rst_req_ready", req_ready, 0);
      check_val("rst_red_in_valid", red_in_valid, 0);
      check_val("rst_rsp_valid", rsp_valid, 0);
      check_val("rst_red_out_ready", red_out_ready, 0);
      check_val("rst_err", err_bad_token, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // 3 + 4, eos(lvl0, stop0) -> single result 7 on lane 0
      send_seg(0, 2, 3, 2'd0, 8'd0);
      drain("t1_drain", 100);
      check_val("t1_rsp_count", rsp_cnt[0], 1);
      check_val("t1_fifo_empty", dut.id_empty_s, 1);

      // lane 1 eos(lvl0, stop2): two results, entry kept until the second
      rsp_ready_cfg = 4'h0;
      send_seg(1, 2, 10, 2'd0, 8'd2);
      k = 0;
      while (res_q.size() < 2 && k < 100) begin cycle(); k++; end
      check_val("t3_results_ready", res_q.size(), 2);
      rsp_ready_cfg = 4'hF; cycle();
      rsp_ready_cfg = 4'h0; cycle();
      check_val("t3_first_routed", rsp_cnt[1], 1);
      check_val("t3_entry_held", dut.id_empty_s, 0);
      rsp_ready_cfg = 4'hF;
      drain("t3_drain", 100);
      check_val("t3_rsp_count", rsp_cnt[1], 2);
      check_val("t3_fifo_empty", dut.id_empty_s, 1);

      // lane 3 segment brings the round-robin pointer back to 0
      send_seg(3, 0, 0, 2'd1, 8'd0);
      drain("align_drain", 100);

      // all four requesters: grant order 0,1,2,3,0 with one bubble between segments
      eos_lane_q.delete(); eos_cyc_q.delete();
      for (int i = 0; i < NR; i++) send_seg(i, 0, 0, 2'd1, 8'(i));
      send_seg(0, 0, 0, 2'd1, 8'd5);
      drain("t2_drain", 200);
      check_val("t2_seg_count", eos_lane_q.size(), 5);
      if (eos_lane_q.size() == 5) begin
         for (int i = 0; i < 5; i++) check_val("t2_grant_order", eos_lane_q[i], i % NR);
         for (int i = 1; i < 5; i++) check_val("t2_gap", eos_cyc_q[i] - eos_cyc_q[i-1], 2);
      end

      // DEPTH segments outstanding with results stalled: next eos must wait
      rsp_ready_cfg = 4'h0;
      eos_lane_q.delete();
      for (int s = 0; s < DEPTH + 1; s++) send_seg(s % NR, 0, 0, 2'd1, 8'(s));
      run(60);
      check_val("t4_accepted", eos_lane_q.size(), DEPTH);
      check_val("t4_req_ready_low", req_ready, 0);
      check_val("t4_red_in_valid_low", red_in_valid, 0);
      check_val("t4_red_out_stalled", red_out_ready, 0);
      check_val("t4_pending_tok", tokq[0].size(), 1);
      rsp_ready_cfg = 4'hF;
      drain("t4_drain", 300);
      check_val("t4_all_accepted", eos_lane_q.size(), DEPTH + 1);

      // mask 1010: only lanes 1 and 3 granted; lvl2 eos sets the sticky error
      cfg_req_mask = 4'b1010;
      eos_lane_q.delete();
      check_val("t5_err_before", err_bad_token, 0);
      send_seg(0, 0, 0, 2'd1, 8'd0);
      send_seg(1, 1, 5, 2'd2, 8'd0);
      send_seg(2, 0, 0, 2'd1, 8'd0);
      send_seg(3, 0, 0, 2'd1, 8'd0);
      run(30);
      check_val("t5_granted_count", eos_lane_q.size(), 2);
      if (eos_lane_q.size() == 2) begin
         check_val("t5_first_lane", eos_lane_q[0], 1);
         check_val("t5_second_lane", eos_lane_q[1], 3);
      end
      check_val("t5_err_set", err_bad_token, 1);
      check_val("t5_lane0_waiting", tokq[0].size(), 1);
      check_val("t5_lane2_waiting", tokq[2].size(), 1);
      cfg_req_mask = 4'hF;
      drain("t5_drain", 100);
      check_val("t5_err_sticky", err_bad_token, 1);
      check_val("t5_total_granted", eos_lane_q.size(), 4);

      // reset in the middle of a lane 2 segment
      send_seg(2, 6, 20, 2'd1, 8'd0);
      k = 0;
      while (tokq[2].size() > 4 && k < 50) begin cycle(); k++; end
      check_val("t6_mid_segment", tokq[2].size(), 4);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("t6_red_in_valid", red_in_valid, 0);
      check_val("t6_req_ready", req_ready, 0);
      check_val("t6_rsp_valid", rsp_valid, 0);
      check_val("t6_err_cleared", err_bad_token, 0);
      clear_all();
      cycle();
      check_val("t6_red_in_valid_next", red_in_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NR; i++) send_seg(i, 0, 0, 2'd1, 8'd0);
      drain("t6_drain", 100);
      check_val("t6_seg_count", eos_lane_q.size(), 4);
      if (eos_lane_q.size() != 0) check_val("t6_first_grant", eos_lane_q[0], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
